// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FSM encodings and the default reset PC live here.
package ysyx_23060201_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch stage: one outstanding fetch, holds the word
// until downstream accepts, then advances or redirects the PC.
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC =
    MEM_ADDR_WIDTH'(IFU_RESET_PC),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                      imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
  input  logic                      imem_rsp_err,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [DATA_WIDTH-1:0]     inst,
  output logic [MEM_ADDR_WIDTH-1:0] pc,
  input  logic                      jump_en,
  input  logic [MEM_ADDR_WIDTH-1:0] dnpc,
  output logic                      fetch_err,
  output logic [31:0]               fetch_cnt
);

  ifu_state_t state, state_nx;

  logic [MEM_ADDR_WIDTH-1:0] pc_nx;
  logic [MEM_ADDR_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0]     inst_nx;
  logic [31:0]               cnt_nx;
  logic [31:0]               timer, timer_nx;
  logic                      timed_out;

  assign next_pc = jump_en ? dnpc : pc + MEM_ADDR_WIDTH'(4);

  // A zero timeout budget disables the watchdog entirely.
  assign timed_out = (TIMEOUT_CYCLES != 0) &&
                     (timer == 32'(TIMEOUT_CYCLES - 1));

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;
  assign inst_valid     = (state == S_HOLD);
  assign fetch_err      = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_cnt <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      inst      <= inst_nx;
      fetch_cnt <= cnt_nx;
      timer     <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = inst;
    cnt_nx   = fetch_cnt;
    timer_nx = timer;
    unique case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_nx = S_WAIT;
          timer_nx = '0;
        end
      end
      S_WAIT: begin
        timer_nx = timer + 32'd1;
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_nx = S_ERR;
          end else begin
            inst_nx  = imem_rsp_data;
            state_nx = S_HOLD;
          end
        end else if (timed_out) begin
          state_nx = S_ERR;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          pc_nx    = next_pc;
          cnt_nx   = fetch_cnt + 32'd1;
          // Misaligned targets are still committed to pc for debug.
          state_nx = (next_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
        end
      end
      S_ERR: state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
